vram_arbiter: RTL and testbench
===============================

VRAM_ARBITER -- requirements
Module: vram_arbiter

Interface
REQ-001 The block SHALL have parameter STARVE_LIMIT, default 8, meaning the number of consecutive stalled cycles before a bus request is promoted.
REQ-002 The block SHALL have parameter AW, default 18, meaning the VRAM word-address width.
REQ-003 wb_clk_i  in  1  the single clock; all logic SHALL be on its rising edge.
REQ-004 wb_rst_i  in  1  reset, synchronous and active-high.
REQ-005 scan_req_i / scan_addr_i / scan_gnt_o / scan_rdata_o / scan_rvalid_o  in/in/out/out/out  1/AW/1/16/1  display scanout read port.
REQ-006 gpu_active_i  in  1  GPU raster active; gpu_req_i is ignored while this is low.
REQ-007 gpu_req_i / gpu_addr_i / gpu_data_i / gpu_gnt_o  in/in/in/out  1/AW/16/1  raster pixel write port.
REQ-008 wbs_stb_i, wbs_cyc_i, wbs_we_i  in  1 each  Wishbone slave controls.
REQ-009 wbs_sel_i  in  2  VRAM is selected only when this equals 2'b01.
REQ-010 wbs_adr_i, wbs_dat_i  in  32 each  the bus address (low AW bits used) and the write data (low 16 bits used).
REQ-011 wbs_ack_o  out  1  the bus acknowledge.
REQ-012 wbs_dat_o  out  32  the bus read data; bits [31:16] are zero.
REQ-013 vram_enable_o / vram_wr_en_o / vram_addr_o / vram_data_o  out/out/out/out  1/1/AW/16  the registered VRAM port.
REQ-014 vram_data_i  in  16  VRAM read data, valid one cycle after an enabled read.

Function
REQ-015 A request is eligible in cycle N only under these conditions:
- scan: scan_req_i.
- gpu: gpu_req_i & gpu_active_i.
- wb: stb & cyc & sel==2'b01 & wb FSM in WB_IDLE.
REQ-016 Exactly one eligible request SHALL be granted per cycle, with priority scan > gpu > wb, except as modified by REQ-026.
REQ-017 scan_gnt_o and gpu_gnt_o SHALL be combinational, asserted in cycle N for the granted requester; the requester treats the request as consumed at the end of N.
REQ-018 VRAM outputs SHALL be registered: the access granted in N appears on vram_* during N+1; vram_enable_o=0 and vram_wr_en_o=0 in any cycle following a cycle with no grant.
REQ-019 A scan grant SHALL drive wr_en=0; scan_rvalid_o SHALL be high in N+2 with scan_rdata_o=vram_data_i; back-to-back scan grants SHALL yield back-to-back rvalid.
REQ-020 A gpu grant SHALL drive wr_en=1, addr=gpu_addr_i, data=gpu_data_i.
REQ-021 The wb FSM SHALL have states WB_IDLE, WB_RD, WB_ACK. On a wb grant:
- write (we=1): WB_IDLE->WB_ACK, with wbs_ack_o=1 in N+1.
- read (we=0): WB_IDLE->WB_RD->WB_ACK, with wbs_ack_o=1 in N+2 and wbs_dat_o={16'b0, vram_data_i} captured in the same cycle.
REQ-022 WB_ACK SHALL last exactly one cycle and return to WB_IDLE; wb SHALL be ineligible in WB_RD and WB_ACK, so that a lingering stb is never re-issued.
REQ-023 wbs_ack_o SHALL be a single-cycle pulse per transaction and SHALL never assert for sel!=2'b01.
REQ-024 A scan or gpu request arriving while the wb FSM is in WB_RD or WB_ACK SHALL be granted normally; the VRAM port is free after the wb access cycle.
REQ-025 If gpu_active_i falls while gpu_req_i is high, no gpu grant SHALL occur from that cycle onward.

Configuration
REQ-026 With macro VRAM_ARB_STARVE_EN defined:
- A saturating counter SHALL count cycles in which wb is eligible but not granted.
- When the counter reaches STARVE_LIMIT, wb SHALL outrank gpu (never scan).
- The counter SHALL clear on a wb grant or when wb is not eligible.
REQ-027 Without VRAM_ARB_STARVE_EN, priority SHALL be strictly fixed and the counter SHALL be absent.

Reset
REQ-028 While wb_rst_i is high, all outputs SHALL be 0, the wb FSM SHALL be in WB_IDLE, the read-valid pipeline SHALL be cleared, and the starvation counter SHALL be 0.
REQ-029 A reset during WB_RD or WB_ACK SHALL abandon the transaction with no ack; a scan read in flight SHALL produce no rvalid.
REQ-030 The first grant SHALL be possible in the first cycle after reset deasserts.

Verification
REQ-031 WB write adr=0x100, dat=0xABCD, sel=01, no other requests -> vram write of 0xABCD to 0x100 in N+1; ack in N+1 only; one VRAM write only, even if stb is held for 3 cycles.
REQ-032 WB read adr=0x20 with VRAM model returning 0x1234 -> ack in N+2, wbs_dat_o=0x00001234.
REQ-033 scan, gpu and wb requests all high in one cycle -> grant order scan, gpu, gpu..., with wb ack only after gpu_req_i drops (starvation feature off).
REQ-034 VRAM_ARB_STARVE_EN with STARVE_LIMIT=8 and gpu_req_i held continuously plus wb write -> wb granted on the 9th eligible cycle, then gpu resumes.
REQ-035 Scan reads on 4 consecutive cycles at addr 0..3 -> scan_rvalid_o high for 4 consecutive cycles with matching data.
REQ-036 Reset asserted in WB_RD -> no ack, all outputs 0; a new WB read after reset completes normally.

Source files
------------

// File: rtl/vram_arbiter.sv
// VRAM arbiter: scan > gpu > wb priority onto one registered VRAM port, with a 3-state wb FSM.
// Define VRAM_ARB_STARVE_EN to let a starved wb request outrank gpu after STARVE_LIMIT stalls.
module vram_arbiter #(
    parameter int STARVE_LIMIT = 8,
    parameter int AW           = 18
) (
    input  logic          wb_clk_i,
    input  logic          wb_rst_i,
    input  logic          scan_req_i,
    input  logic [AW-1:0] scan_addr_i,
    output logic          scan_gnt_o,
    output logic [15:0]   scan_rdata_o,
    output logic          scan_rvalid_o,
    input  logic          gpu_active_i,
    input  logic          gpu_req_i,
    input  logic [AW-1:0] gpu_addr_i,
    input  logic [15:0]   gpu_data_i,
    output logic          gpu_gnt_o,
    input  logic          wbs_stb_i,
    input  logic          wbs_cyc_i,
    input  logic          wbs_we_i,
    input  logic [1:0]    wbs_sel_i,
    input  logic [31:0]   wbs_adr_i,
    input  logic [31:0]   wbs_dat_i,
    output logic          wbs_ack_o,
    output logic [31:0]   wbs_dat_o,
    output logic          vram_enable_o,
    output logic          vram_wr_en_o,
    output logic [AW-1:0] vram_addr_o,
    output logic [15:0]   vram_data_o,
    input  logic [15:0]   vram_data_i
);

    typedef enum logic [1:0] {
        WB_IDLE = 2'd0,
        WB_RD   = 2'd1,
        WB_ACK  = 2'd2
    } wb_state_t;

    wb_state_t     r_wb_state;
    wb_state_t     w_wb_state_nxt;
    logic          w_scan_elig;
    logic          w_gpu_elig;
    logic          w_wb_elig;
    logic          w_wb_promote;
    logic          w_scan_gnt;
    logic          w_gpu_gnt;
    logic          w_wb_gnt;
    logic [1:0]    r_scan_pipe;
    logic          r_wb_rd;
    logic [15:0]   r_wb_rdata;
    logic          r_vram_enable;
    logic          r_vram_wr_en;
    logic [AW-1:0] r_vram_addr;
    logic [15:0]   r_vram_data;
    logic          w_unused;

    // Request eligibility; nothing is eligible while reset is held
    always_comb begin
        w_scan_elig = scan_req_i & ~wb_rst_i;
        w_gpu_elig  = gpu_req_i & gpu_active_i & ~wb_rst_i;
        w_wb_elig   = wbs_stb_i & wbs_cyc_i & (wbs_sel_i == 2'b01) &
                      (r_wb_state == WB_IDLE) & ~wb_rst_i;
    end

`ifdef VRAM_ARB_STARVE_EN
    localparam int CW = $clog2(STARVE_LIMIT + 1);
    logic [CW-1:0] r_starve_cnt;

    assign w_wb_promote = (r_starve_cnt >= CW'(STARVE_LIMIT));

    // Saturating count of cycles where wb was eligible but lost arbitration
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_starve_cnt <= '0;
        end else if (w_wb_elig && !w_wb_gnt) begin
            if (!w_wb_promote) begin
                r_starve_cnt <= r_starve_cnt + CW'(1'b1);
            end else begin
                r_starve_cnt <= r_starve_cnt;
            end
        end else begin
            r_starve_cnt <= '0;
        end
    end
`else
    assign w_wb_promote = 1'b0;
`endif

    // One grant per cycle; a promoted wb request jumps ahead of gpu only
    always_comb begin
        w_scan_gnt = 1'b0;
        w_gpu_gnt  = 1'b0;
        w_wb_gnt   = 1'b0;
        if (w_scan_elig) begin
            w_scan_gnt = 1'b1;
        end else if (w_wb_elig && w_wb_promote) begin
            w_wb_gnt = 1'b1;
        end else if (w_gpu_elig) begin
            w_gpu_gnt = 1'b1;
        end else if (w_wb_elig) begin
            w_wb_gnt = 1'b1;
        end else begin
            w_wb_gnt = 1'b0;
        end
    end

    // wb FSM next state: reads wait one extra cycle for VRAM data
    always_comb begin
        w_wb_state_nxt = r_wb_state;
        case (r_wb_state)
            WB_IDLE: begin
                if (w_wb_gnt) begin
                    w_wb_state_nxt = wbs_we_i ? WB_ACK : WB_RD;
                end else begin
                    w_wb_state_nxt = WB_IDLE;
                end
            end
            WB_RD:   w_wb_state_nxt = WB_ACK;
            WB_ACK:  w_wb_state_nxt = WB_IDLE;
            default: w_wb_state_nxt = WB_IDLE;
        endcase
    end

    // wb FSM state register and transaction direction
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_wb_state <= WB_IDLE;
            r_wb_rd    <= 1'b0;
        end else begin
            r_wb_state <= w_wb_state_nxt;
            if (w_wb_gnt) begin
                r_wb_rd <= ~wbs_we_i;
            end else begin
                r_wb_rd <= r_wb_rd;
            end
        end
    end

    // Registered VRAM port; address/data hold when idle, enables drop to zero
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_vram_enable <= 1'b0;
            r_vram_wr_en  <= 1'b0;
            r_vram_addr   <= '0;
            r_vram_data   <= 16'h0000;
        end else begin
            r_vram_enable <= w_scan_gnt | w_gpu_gnt | w_wb_gnt;
            r_vram_wr_en  <= w_gpu_gnt | (w_wb_gnt & wbs_we_i);
            if (w_scan_gnt) begin
                r_vram_addr <= scan_addr_i;
            end else if (w_gpu_gnt) begin
                r_vram_addr <= gpu_addr_i;
                r_vram_data <= gpu_data_i;
            end else if (w_wb_gnt) begin
                r_vram_addr <= wbs_adr_i[AW-1:0];
                r_vram_data <= wbs_dat_i[15:0];
            end else begin
                r_vram_addr <= r_vram_addr;
                r_vram_data <= r_vram_data;
            end
        end
    end

    // Scan read-valid pipeline: grant -> VRAM access -> data return
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_scan_pipe <= 2'b00;
        end else begin
            r_scan_pipe <= {r_scan_pipe[0], w_scan_gnt};
        end
    end

    // Keep the last wb read word so wbs_dat_o stays stable after the ack
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_wb_rdata <= 16'h0000;
        end else if ((r_wb_state == WB_ACK) && r_wb_rd) begin
            r_wb_rdata <= vram_data_i;
        end else begin
            r_wb_rdata <= r_wb_rdata;
        end
    end

    assign scan_gnt_o    = w_scan_gnt;
    assign gpu_gnt_o     = w_gpu_gnt;
    assign scan_rvalid_o = r_scan_pipe[1];
    assign scan_rdata_o  = r_scan_pipe[1] ? vram_data_i : 16'h0000;
    assign wbs_ack_o     = (r_wb_state == WB_ACK);
    assign wbs_dat_o     = {16'h0000, (wbs_ack_o && r_wb_rd) ? vram_data_i : r_wb_rdata};
    assign vram_enable_o = r_vram_enable;
    assign vram_wr_en_o  = r_vram_wr_en;
    assign vram_addr_o   = r_vram_addr;
    assign vram_data_o   = r_vram_data;

    assign w_unused = ^{wbs_adr_i[31:AW], wbs_dat_i[31:16], (STARVE_LIMIT > 0)};

endmodule

// File: tb/tb_vram_arbiter.sv
// Self-checking bench for vram_arbiter: vector table, directed corner sequences and
// randomized traffic against a cycle-level reference model plus a behavioural VRAM.
module tb_vram_arbiter;
    localparam int AW    = 18;
    localparam int LIMIT = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          scan_req_i;
    logic [AW-1:0] scan_addr_i;
    logic          scan_gnt_o;
    logic [15:0]   scan_rdata_o;
    logic          scan_rvalid_o;
    logic          gpu_active_i;
    logic          gpu_req_i;
    logic [AW-1:0] gpu_addr_i;
    logic [15:0]   gpu_data_i;
    logic          gpu_gnt_o;
    logic          wbs_stb_i;
    logic          wbs_cyc_i;
    logic          wbs_we_i;
    logic [1:0]    wbs_sel_i;
    logic [31:0]   wbs_adr_i;
    logic [31:0]   wbs_dat_i;
    logic          wbs_ack_o;
    logic [31:0]   wbs_dat_o;
    logic          vram_enable_o;
    logic          vram_wr_en_o;
    logic [AW-1:0] vram_addr_o;
    logic [15:0]   vram_data_o;
    logic [15:0]   vram_data_i;

    always #5 clk = ~clk;

    vram_arbiter #(.STARVE_LIMIT(LIMIT), .AW(AW)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .scan_req_i(scan_req_i), .scan_addr_i(scan_addr_i), .scan_gnt_o(scan_gnt_o),
        .scan_rdata_o(scan_rdata_o), .scan_rvalid_o(scan_rvalid_o),
        .gpu_active_i(gpu_active_i), .gpu_req_i(gpu_req_i), .gpu_addr_i(gpu_addr_i),
        .gpu_data_i(gpu_data_i), .gpu_gnt_o(gpu_gnt_o),
        .wbs_stb_i(wbs_stb_i), .wbs_cyc_i(wbs_cyc_i), .wbs_we_i(wbs_we_i),
        .wbs_sel_i(wbs_sel_i), .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i),
        .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
        .vram_enable_o(vram_enable_o), .vram_wr_en_o(vram_wr_en_o),
        .vram_addr_o(vram_addr_o), .vram_data_o(vram_data_o), .vram_data_i(vram_data_i)
    );

    function automatic logic [15:0] init_val(input int a);
        if (a == 32'h20) return 16'h1234;
        return 16'hC000 | 16'(a);
    endfunction

    // Behavioural VRAM: read data appears the cycle after an enabled read
    logic [15:0] mem [0:1023];
    logic        mem_ready = 1'b0;
    int          wr_count  = 0;
    always @(posedge clk) begin
        if (!mem_ready) begin
            for (int i = 0; i < 1024; i++) mem[i] <= init_val(i);
            mem_ready <= 1'b1;
        end else if (vram_enable_o) begin
            if (vram_wr_en_o) begin
                mem[vram_addr_o[9:0]] <= vram_data_o;
                wr_count <= wr_count + 1;
            end else begin
                vram_data_i <= mem[vram_addr_o[9:0]];
            end
        end
    end

    // Reference model state: expected outputs one and two cycles ahead
    typedef struct packed {
        logic          en;
        logic          wr;
        logic [AW-1:0] addr;
        logic [15:0]   data;
        logic          ack;
        logic          ard;
        logic [15:0]   ackdat;
        logic          rv;
        logic [15:0]   rdat;
    } exp_t;

    logic [15:0] ref_mem [0:1023];
    exp_t        p1, p2, cur;
    int          blk, starve;
    logic        obs_sg, obs_gg;
    int          checks = 0;
    int          errors = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, got, want, $time);
        end
    endtask

    function automatic logic any_out();
        return (scan_gnt_o | gpu_gnt_o | scan_rvalid_o | wbs_ack_o | vram_enable_o | vram_wr_en_o) ||
               (scan_rdata_o != 16'h0) || (wbs_dat_o != 32'h0) ||
               (vram_addr_o != '0) || (vram_data_o != 16'h0);
    endfunction

    // One clock: inputs already driven after a falling edge; checks grants, then registered outputs
    task automatic cycle();
        logic          es, eg, ew, promote;
        int            win;
        logic [AW-1:0] wa;
        #1;
        es = scan_req_i;
        eg = gpu_req_i & gpu_active_i;
        ew = wbs_stb_i & wbs_cyc_i & (wbs_sel_i == 2'b01) & (blk == 0);
`ifdef VRAM_ARB_STARVE_EN
        promote = (starve >= LIMIT);
`else
        promote = 1'b0;
`endif
        if (rst)                win = 0;
        else if (es)            win = 1;
        else if (ew && promote) win = 3;
        else if (eg)            win = 2;
        else if (ew)            win = 3;
        else                    win = 0;
        obs_sg = scan_gnt_o;
        obs_gg = gpu_gnt_o;
        chk("scan_gnt", 32'(obs_sg), 32'(win == 1));
        chk("gpu_gnt", 32'(obs_gg), 32'(win == 2));
        if (rst) begin
            p1 = '0; p2 = '0; blk = 0; starve = 0;
        end else begin
            if (ew && win != 3) starve = (starve < LIMIT) ? starve + 1 : LIMIT;
            else                starve = 0;
            if (blk > 0) blk--;
            case (win)
                1: begin
                    p1.en = 1'b1; p1.wr = 1'b0; p1.addr = scan_addr_i;
                    p2.rv = 1'b1; p2.rdat = ref_mem[scan_addr_i[9:0]];
                end
                2: begin
                    p1.en = 1'b1; p1.wr = 1'b1; p1.addr = gpu_addr_i; p1.data = gpu_data_i;
                    ref_mem[gpu_addr_i[9:0]] = gpu_data_i;
                end
                3: begin
                    wa = wbs_adr_i[AW-1:0];
                    p1.en = 1'b1; p1.addr = wa;
                    if (wbs_we_i) begin
                        p1.wr = 1'b1; p1.data = wbs_dat_i[15:0]; p1.ack = 1'b1;
                        ref_mem[wa[9:0]] = wbs_dat_i[15:0];
                        blk = 1;
                    end else begin
                        p1.wr = 1'b0;
                        p2.ack = 1'b1; p2.ard = 1'b1; p2.ackdat = ref_mem[wa[9:0]];
                        blk = 2;
                    end
                end
                default: ;
            endcase
        end
        @(posedge clk);
        #1;
        cur = p1; p1 = p2; p2 = '0;
        chk("vram_en", 32'(vram_enable_o), 32'(cur.en));
        chk("vram_wr", 32'(vram_wr_en_o), 32'(cur.wr));
        if (cur.en) chk("vram_addr", 32'(vram_addr_o), 32'(cur.addr));
        if (cur.en && cur.wr) chk("vram_data", 32'(vram_data_o), 32'(cur.data));
        chk("wb_ack", 32'(wbs_ack_o), 32'(cur.ack));
        if (cur.ard) chk("wb_dat", wbs_dat_o, {16'h0000, cur.ackdat});
        chk("scan_rvalid", 32'(scan_rvalid_o), 32'(cur.rv));
        if (cur.rv) chk("scan_rdata", 32'(scan_rdata_o), 32'(cur.rdat));
        if (rst) chk("rst_outputs_zero", 32'(any_out()), 32'd0);
        @(negedge clk);
    endtask

    task automatic idle();
        scan_req_i = 1'b0; scan_addr_i = '0;
        gpu_req_i = 1'b0; gpu_active_i = 1'b0; gpu_addr_i = '0; gpu_data_i = 16'h0;
        wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0; wbs_we_i = 1'b0; wbs_sel_i = 2'b01;
        wbs_adr_i = 32'h0; wbs_dat_i = 32'h0;
    endtask

    task automatic set_wb(input logic on, input logic we, input logic [31:0] adr, input logic [31:0] dat);
        wbs_stb_i = on; wbs_cyc_i = on; wbs_we_i = we; wbs_sel_i = 2'b01;
        wbs_adr_i = adr; wbs_dat_i = dat;
    endtask

    typedef struct packed {
        logic       scan, gpu, act, wb, we;
        logic [1:0] sel;
        logic       sg, gg, en, wr, ack;
    } vec_t;

    vec_t tbl [14];
    int   n0;

    initial begin
        for (int i = 0; i < 1024; i++) ref_mem[i] = init_val(i);
        p1 = '0; p2 = '0; cur = '0; blk = 0; starve = 0;
        idle();
        rst = 1'b1;
        @(negedge clk);
        cycle();
        cycle();
        rst = 1'b0;

        //               scan gpu act wb we sel    sg gg en wr ack
        tbl[0]  = '{1'b0,1'b0,1'b0,1'b0,1'b0,2'b01, 1'b0,1'b0,1'b0,1'b0,1'b0};
        tbl[1]  = '{1'b1,1'b0,1'b0,1'b0,1'b0,2'b01, 1'b1,1'b0,1'b1,1'b0,1'b0};
        tbl[2]  = '{1'b0,1'b1,1'b1,1'b0,1'b0,2'b01, 1'b0,1'b1,1'b1,1'b1,1'b0};
        tbl[3]  = '{1'b0,1'b1,1'b0,1'b0,1'b0,2'b01, 1'b0,1'b0,1'b0,1'b0,1'b0};
        tbl[4]  = '{1'b1,1'b1,1'b1,1'b0,1'b0,2'b01, 1'b1,1'b0,1'b1,1'b0,1'b0};
        tbl[5]  = '{1'b0,1'b0,1'b0,1'b1,1'b1,2'b01, 1'b0,1'b0,1'b1,1'b1,1'b1};
        tbl[6]  = '{1'b0,1'b0,1'b0,1'b0,1'b0,2'b01, 1'b0,1'b0,1'b0,1'b0,1'b0};
        tbl[7]  = '{1'b0,1'b0,1'b0,1'b1,1'b1,2'b10, 1'b0,1'b0,1'b0,1'b0,1'b0};
        tbl[8]  = '{1'b0,1'b0,1'b0,1'b1,1'b0,2'b11, 1'b0,1'b0,1'b0,1'b0,1'b0};
        tbl[9]  = '{1'b0,1'b1,1'b1,1'b1,1'b1,2'b01, 1'b0,1'b1,1'b1,1'b1,1'b0};
        tbl[10] = '{1'b0,1'b0,1'b0,1'b1,1'b0,2'b01, 1'b0,1'b0,1'b1,1'b0,1'b0};
        tbl[11] = '{1'b0,1'b1,1'b1,1'b1,1'b0,2'b01, 1'b0,1'b1,1'b1,1'b1,1'b1};
        tbl[12] = '{1'b1,1'b0,1'b0,1'b1,1'b0,2'b01, 1'b1,1'b0,1'b1,1'b0,1'b0};
        tbl[13] = '{1'b0,1'b0,1'b0,1'b0,1'b0,2'b01, 1'b0,1'b0,1'b0,1'b0,1'b0};
        for (int i = 0; i < 14; i++) begin
            scan_req_i = tbl[i].scan; scan_addr_i = 18'(i);
            gpu_req_i = tbl[i].gpu; gpu_active_i = tbl[i].act;
            gpu_addr_i = 18'h100 + 18'(i); gpu_data_i = 16'h0A00 + 16'(i);
            wbs_stb_i = tbl[i].wb; wbs_cyc_i = tbl[i].wb; wbs_we_i = tbl[i].we;
            wbs_sel_i = tbl[i].sel; wbs_adr_i = 32'h200 + 32'(i); wbs_dat_i = 32'hBEE0 + 32'(i);
            cycle();
            chk($sformatf("tbl%0d_scan_gnt", i), 32'(obs_sg), 32'(tbl[i].sg));
            chk($sformatf("tbl%0d_gpu_gnt", i), 32'(obs_gg), 32'(tbl[i].gg));
            chk($sformatf("tbl%0d_vram_en", i), 32'(vram_enable_o), 32'(tbl[i].en));
            chk($sformatf("tbl%0d_vram_wr", i), 32'(vram_wr_en_o), 32'(tbl[i].wr));
            chk($sformatf("tbl%0d_ack", i), 32'(wbs_ack_o), 32'(tbl[i].ack));
        end

        // wb write held across a scan stall, the grant and the ack cycle: one write only
        idle();
        scan_req_i = 1'b1;
        set_wb(1'b1, 1'b1, 32'h100, 32'hABCD);
        cycle();
        chk("w31_scan_first", 32'(obs_sg), 32'd1);
        n0 = wr_count;
        scan_req_i = 1'b0;
        cycle();
        chk("w31_en", 32'(vram_enable_o), 32'd1);
        chk("w31_wr", 32'(vram_wr_en_o), 32'd1);
        chk("w31_addr", 32'(vram_addr_o), 32'h100);
        chk("w31_data", 32'(vram_data_o), 32'hABCD);
        chk("w31_ack", 32'(wbs_ack_o), 32'd1);
        cycle();
        chk("w31_ack_once", 32'(wbs_ack_o), 32'd0);
        chk("w31_no_reissue", 32'(vram_enable_o), 32'd0);
        set_wb(1'b0, 1'b0, 32'h0, 32'h0);
        cycle();
        chk("w31_write_count", 32'(wr_count - n0), 32'd1);

        // wb read of preloaded word: ack two cycles after grant with zero-extended data
        set_wb(1'b1, 1'b0, 32'h20, 32'h0);
        cycle();
        chk("r32_addr", 32'(vram_addr_o), 32'h20);
        chk("r32_no_early_ack", 32'(wbs_ack_o), 32'd0);
        cycle();
        chk("r32_ack", 32'(wbs_ack_o), 32'd1);
        chk("r32_dat", wbs_dat_o, 32'h0000_1234);
        set_wb(1'b0, 1'b0, 32'h0, 32'h0);
        cycle();
        chk("r32_ack_done", 32'(wbs_ack_o), 32'd0);

        // All three request together: scan, then gpu while it holds, then wb
        scan_req_i = 1'b1; gpu_req_i = 1'b1; gpu_active_i = 1'b1;
        gpu_addr_i = 18'h150; gpu_data_i = 16'h6666;
        set_wb(1'b1, 1'b1, 32'h140, 32'h5555);
        cycle();
        chk("p33_scan", 32'(obs_sg), 32'd1);
        scan_req_i = 1'b0;
        for (int k = 0; k < 2; k++) begin
            cycle();
            chk("p33_gpu", 32'(obs_gg), 32'd1);
            chk("p33_wb_waits", 32'(wbs_ack_o), 32'd0);
        end
        gpu_req_i = 1'b0;
        cycle();
        chk("p33_wb_ack", 32'(wbs_ack_o), 32'd1);
        chk("p33_wb_addr", 32'(vram_addr_o), 32'h140);
        idle();
        cycle();

        // Back-to-back scan reads produce back-to-back rvalid
        for (int i = 0; i < 6; i++) begin
            scan_req_i = (i < 4);
            scan_addr_i = 18'(i);
            cycle();
            chk("s35_rvalid", 32'(scan_rvalid_o), 32'((i >= 1) && (i <= 4)));
            if (i >= 1 && i <= 4) chk("s35_rdata", 32'(scan_rdata_o), 32'(16'hC000 + 16'(i - 1)));
        end

        // Reset with a scan read in flight: no rvalid afterwards
        idle();
        scan_req_i = 1'b1; scan_addr_i = 18'h5;
        cycle();
        rst = 1'b1;
        cycle();
        chk("x36_scan_killed", 32'(scan_rvalid_o), 32'd0);
        rst = 1'b0;
        idle();
        cycle();
        chk("x36_no_late_rvalid", 32'(scan_rvalid_o), 32'd0);

        // Reset while the wb read sits in WB_RD: no ack, outputs cleared, next read works
        set_wb(1'b1, 1'b0, 32'h40, 32'h0);
        cycle();
        chk("x36_rd_ack0", 32'(wbs_ack_o), 32'd0);
        rst = 1'b1; scan_req_i = 1'b1; gpu_req_i = 1'b1; gpu_active_i = 1'b1;
        cycle();
        chk("x36_gnts_in_rst", 32'({obs_sg, obs_gg}), 32'd0);
        chk("x36_all_zero", 32'(any_out()), 32'd0);
        rst = 1'b0; gpu_req_i = 1'b0;
        set_wb(1'b0, 1'b0, 32'h0, 32'h0);
        cycle();
        chk("x36_first_grant", 32'(obs_sg), 32'd1);
        chk("x36_no_ack", 32'(wbs_ack_o), 32'd0);
        scan_req_i = 1'b0;
        set_wb(1'b1, 1'b0, 32'h20, 32'h0);
        cycle();
        cycle();
        chk("x36_new_read_ack", 32'(wbs_ack_o), 32'd1);
        chk("x36_new_read_dat", wbs_dat_o, 32'h0000_1234);
        idle();
        cycle();

`ifdef VRAM_ARB_STARVE_EN
        // gpu held continuously: wb write wins on its (LIMIT+1)th eligible cycle
        gpu_req_i = 1'b1; gpu_active_i = 1'b1; gpu_addr_i = 18'h160; gpu_data_i = 16'h1111;
        set_wb(1'b1, 1'b1, 32'h180, 32'h7777);
        for (int k = 1; k <= LIMIT + 2; k++) begin
            if (k == LIMIT + 2) set_wb(1'b0, 1'b0, 32'h0, 32'h0);
            cycle();
            chk($sformatf("st34_gpu_gnt_c%0d", k), 32'(obs_gg), 32'(k != LIMIT + 1));
            chk($sformatf("st34_ack_c%0d", k), 32'(wbs_ack_o), 32'(k == LIMIT + 1));
        end
        idle();
        cycle();
`endif

        // Randomized traffic against the reference model
        for (int c = 0; c < 3000; c++) begin
            rst          = ($urandom_range(0, 99) == 0);
            scan_req_i   = ($urandom_range(0, 3) == 0);
            scan_addr_i  = 18'h300 + 18'($urandom_range(0, 15));
            gpu_req_i    = 1'($urandom_range(0, 1));
            gpu_active_i = ($urandom_range(0, 3) != 0);
            gpu_addr_i   = 18'h300 + 18'($urandom_range(0, 15));
            gpu_data_i   = 16'($urandom);
            wbs_stb_i    = 1'($urandom_range(0, 1));
            wbs_cyc_i    = ($urandom_range(0, 7) != 0);
            wbs_sel_i    = ($urandom_range(0, 5) == 0) ? 2'($urandom) : 2'b01;
            wbs_we_i     = 1'($urandom_range(0, 1));
            wbs_adr_i    = {14'($urandom), 18'h300 + 18'($urandom_range(0, 15))};
            wbs_dat_i    = $urandom;
            cycle();
        end
        rst = 1'b0;
        idle();
        cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
